// File: rtl/framebuffer_arbiter_pkg.sv
// Shared types and helpers for the framebuffer arbiter and its scheduler.
//   fb_state_e  : scheduler state encoding
//   OVERRUN_W   : width of the saturating overrun counter
//   addr_width  : address width needed for a cols x rows framebuffer
package fb_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        STEP  = 2'd2,
        RUN   = 2'd3
    } fb_state_e;

    localparam int OVERRUN_W = 8;

    function automatic int addr_width(input int cols, input int rows);
        return (cols * rows <= 1) ? 1 : $clog2(cols * rows);
    endfunction

endpackage

// File: rtl/framebuffer_arbiter_if.sv
// Engine-side access bus of the framebuffer arbiter.
//   master : sand engine (drives req/we/addr/wdata, sees gnt/rvalid/rdata)
//   slave  : arbiter
// The engine holds req and its payload until it sees gnt high.
interface framebuffer_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/framebuffer_arbiter_scheduler.sv
// Generation scheduler: state machine, clear address counter, pending-clear
// flag and saturating overrun counter.
//   clk_i, reset_i    : clock, async active-low reset
//   video_en_i        : display owns the RAM this cycle (clear write stalls)
//   frame_done_i      : last visible pixel is being displayed
//   enable_i          : allow new steps
//   clear_i, done_i   : clear request, engine generation finished
//   state_o, clr_addr_o, step_o, clear_busy_o, overrun_cnt_o
//
// state | meaning
// CLEAR | zero-fill RAM, one word per non-display cycle
// IDLE  | wait for pending clear or end of frame
// STEP  | one-cycle step pulse to the engine
// RUN   | engine owns the non-display cycles until done_i
module framebuffer_scheduler
    import fb_arbiter_pkg::*;
#(
    parameter int DEPTH  = 307200,
    parameter int ADDR_W = 19
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 video_en_i,
    input  logic                 frame_done_i,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic                 done_i,
    output fb_state_e            state_o,
    output logic [ADDR_W-1:0]    clr_addr_o,
    output logic                 step_o,
    output logic                 clear_busy_o,
    output logic [OVERRUN_W-1:0] overrun_cnt_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fb_state_e            r_state;
    logic [ADDR_W-1:0]    r_clr_addr;
    logic                 r_clear_pending;
    logic [OVERRUN_W-1:0] r_overrun;
    logic                 r_step;
    logic                 r_clear_busy;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state         <= CLEAR;
            r_clr_addr      <= '0;
            r_clear_pending <= 1'b0;
            r_overrun       <= '0;
            r_step          <= 1'b0;
            r_clear_busy    <= 1'b1;
        end else begin
            r_step <= 1'b0;
            // A request during a clear is absorbed by that clear.
            if (clear_i && r_state != CLEAR) begin
                r_clear_pending <= 1'b1;
            end
            case (r_state)
                CLEAR: begin
                    if (!video_en_i) begin
                        if (r_clr_addr == LAST_ADDR) begin
                            r_clr_addr   <= '0;
                            r_state      <= IDLE;
                            r_clear_busy <= 1'b0;
                        end else begin
                            r_clr_addr <= r_clr_addr + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (r_clear_pending) begin
                        r_clear_pending <= 1'b0;
                        r_state         <= CLEAR;
                        r_clear_busy    <= 1'b1;
                    end else if (frame_done_i && enable_i) begin
                        r_state <= STEP;
                        r_step  <= 1'b1;
                    end
                end
                STEP: begin
                    r_state <= RUN;
                end
                RUN: begin
                    // done_i wins over a coincident frame end: no overrun.
                    if (done_i) begin
                        r_state <= IDLE;
                    end else if (frame_done_i && r_overrun != '1) begin
                        r_overrun <= r_overrun + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign state_o       = r_state;
    assign clr_addr_o    = r_clr_addr;
    assign step_o        = r_step;
    assign clear_busy_o  = r_clear_busy;
    assign overrun_cnt_o = r_overrun;

endmodule

// File: rtl/framebuffer_arbiter.sv
// Framebuffer arbiter: shares a single-port, 1-cycle-read RAM between the
// display path, the internal clear engine and the sand engine, and schedules
// one simulation step per displayed frame.
//   clk_i, reset_i            : clock, async active-low reset
//   video_en_i, pixel_i       : display request from the sync generator
//   enable_i, clear_i, done_i : scheduling controls
//   eng                       : engine access bus (slave side)
//   step_o, clear_busy_o, overrun_cnt_o : scheduler status
//   pixel_data_o, pixel_valid_o         : display pixel, 2 cycles after pixel_i
//   ram_*                     : framebuffer RAM port
// Priority each cycle: display > clear > engine.
module framebuffer_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter  int ACTIVE_COLUMNS = 640,
    parameter  int ACTIVE_ROWS    = 480,
    parameter  int DATA_W         = 8,
    localparam int DEPTH          = ACTIVE_COLUMNS * ACTIVE_ROWS,
    localparam int ADDR_W         = addr_width(ACTIVE_COLUMNS, ACTIVE_ROWS)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   video_en_i,
    input  logic [ADDR_W-1:0]      pixel_i,
    input  logic                   enable_i,
    input  logic                   clear_i,
    input  logic                   done_i,
    framebuffer_arbiter_if.slave   eng,
    output logic                   step_o,
    output logic                   clear_busy_o,
    output logic [OVERRUN_W-1:0]   overrun_cnt_o,
    output logic [DATA_W-1:0]      pixel_data_o,
    output logic                   pixel_valid_o,
    output logic [ADDR_W-1:0]      ram_addr_o,
    output logic                   ram_we_o,
    output logic [DATA_W-1:0]      ram_wdata_o,
    input  logic [DATA_W-1:0]      ram_rdata_i
);

    localparam logic [ADDR_W-1:0] LAST_PIXEL = ADDR_W'(DEPTH - 1);

    fb_state_e         w_state;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_frame_done;
    logic              w_gnt;

    logic              r_rvalid;
    logic [DATA_W-1:0] r_pixel_data;
    logic              r_video_en_d1;
    logic              r_video_en_d2;

    assign w_frame_done = video_en_i && (pixel_i == LAST_PIXEL);
    assign w_gnt        = !video_en_i && (w_state == RUN) && eng.req;

    framebuffer_scheduler #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_scheduler (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .video_en_i    (video_en_i),
        .frame_done_i  (w_frame_done),
        .enable_i      (enable_i),
        .clear_i       (clear_i),
        .done_i        (done_i),
        .state_o       (w_state),
        .clr_addr_o    (w_clr_addr),
        .step_o        (step_o),
        .clear_busy_o  (clear_busy_o),
        .overrun_cnt_o (overrun_cnt_o)
    );

    always_comb begin
        ram_addr_o  = eng.addr;
        ram_we_o    = 1'b0;
        ram_wdata_o = eng.wdata;
        if (video_en_i) begin
            ram_addr_o = pixel_i;
        end else if (w_state == CLEAR) begin
            ram_addr_o  = w_clr_addr;
            ram_we_o    = 1'b1;
            ram_wdata_o = '0;
        end else if (w_gnt) begin
            ram_we_o = eng.we;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rvalid      <= 1'b0;
            r_pixel_data  <= '0;
            r_video_en_d1 <= 1'b0;
            r_video_en_d2 <= 1'b0;
        end else begin
            r_rvalid      <= w_gnt && !eng.we;
            r_pixel_data  <= ram_rdata_i;
            r_video_en_d1 <= video_en_i;
            r_video_en_d2 <= r_video_en_d1;
        end
    end

    // Engine read data comes straight from the RAM in the cycle after the
    // grant; it is masked so the bus stays quiet when nothing was read.
    assign eng.gnt       = w_gnt;
    assign eng.rvalid    = r_rvalid;
    assign eng.rdata     = r_rvalid ? ram_rdata_i : '0;
    assign pixel_data_o  = r_pixel_data;
    assign pixel_valid_o = r_video_en_d2;

endmodule
